// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, pattern lengths,
// LED width, and the pure pattern decode used by the controller.
package led_seq_pkg;

    localparam int LED_W  = 8;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        FILL_UP = 2'd0,
        FILL_DN = 2'd1,
        CHASE   = 2'd2,
        BLINK   = 2'd3
    } mode_t;

    localparam logic [STEP_W-1:0] LEN_FILL_UP = 4'd9;
    localparam logic [STEP_W-1:0] LEN_FILL_DN = 4'd9;
    localparam logic [STEP_W-1:0] LEN_CHASE   = 4'd8;
    localparam logic [STEP_W-1:0] LEN_BLINK   = 4'd8;

    // Number of steps in the pattern of a given mode
    function automatic logic [STEP_W-1:0] pattern_len(input mode_t m);
        case (m)
            FILL_UP: pattern_len = LEN_FILL_UP;
            FILL_DN: pattern_len = LEN_FILL_DN;
            CHASE:   pattern_len = LEN_CHASE;
            default: pattern_len = LEN_BLINK;
        endcase
    endfunction

    // Modes rotate FILL_UP -> FILL_DN -> CHASE -> BLINK -> FILL_UP
    function automatic mode_t next_mode(input mode_t m);
        next_mode = mode_t'(m + 2'd1);
    endfunction

    // LED image for a mode/step pair; steps beyond a mode's length never occur
    function automatic logic [LED_W-1:0] pattern(input mode_t m, input logic [STEP_W-1:0] s);
        case (m)
            FILL_UP: pattern = 8'hFF >> (4'd8 - s);
            FILL_DN: pattern = ~(8'hFF >> s);
            CHASE:   pattern = 8'h01 << s;
            default: pattern = s[0] ? 8'hFF : 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Prescaler for the LED sequencer: counts 0..DIV-1 while enabled and
// emits a tick during the last count. Clearing restarts the step period.
module tick_gen #(
    parameter int DIV = 25000000
) (
    input  logic clki,
    input  logic rs,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] pcnt;

    // Prescale counter: clear wins, otherwise advance and wrap only when enabled
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + CW'(1);
        end
    end

    assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: steps through one of four 8-bit patterns at a
// prescaled rate, advancing the mode on a button pulse or, optionally,
// automatically at the end of each pattern cycle.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DIV  = 25000000,
    parameter int AUTO = 1
) (
    input  logic             clki,
    input  logic             rs,
    input  logic             btn_next,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             step_tick,
    output logic             cycle_done
);

    mode_t              mode_q;
    logic [STEP_W-1:0]  step;
    logic               tick;

    // A button press restarts the step period so the new mode gets a full first step
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clki (clki),
        .rs   (rs),
        .en   (!pause),
        .clr  (btn_next),
        .tick (tick)
    );

    // Mode/step FSM with led and pulses registered on the same edge as the state
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            mode_q     <= FILL_UP;
            step       <= '0;
            led        <= '0;
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
        end else if (btn_next) begin
            mode_q     <= next_mode(mode_q);
            step       <= '0;
            led        <= pattern(next_mode(mode_q), '0);
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
        end else if (tick) begin
            step_tick <= 1'b1;
            if (step == pattern_len(mode_q) - 4'd1) begin
                step       <= '0;
                cycle_done <= 1'b1;
                if (AUTO != 0) begin
                    mode_q <= next_mode(mode_q);
                    led    <= pattern(next_mode(mode_q), '0);
                end else begin
                    led    <= pattern(mode_q, '0);
                end
            end else begin
                step       <= step + 4'd1;
                led        <= pattern(mode_q, step + 4'd1);
                cycle_done <= 1'b0;
            end
        end else begin
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with DIV=4. Two instances (AUTO=1 and
// AUTO=0) share all inputs and are checked against a table-driven model.
module tb_led_seq_ctrl;

    localparam int DIV = 4;

    logic       clki;
    logic       rs;
    logic       btnNext;
    logic       pause;
    logic [7:0] ledO  [2];
    logic [1:0] modeO [2];
    logic       stO   [2];
    logic       cdO   [2];

    int passCount  = 0;
    int checkCount = 0;

    // Reference patterns written out literally, padded to 9 entries
    logic [7:0] seqTab [4][9] = '{
        '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF},
        '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF},
        '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00},
        '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00}
    };
    int seqLen [4] = '{9, 9, 8, 8};
    int autoOf [2] = '{1, 0};

    int mPcnt [2];
    int mMode [2];
    int mStep [2];
    bit mSt   [2];
    bit mCd   [2];

    led_seq_ctrl #(.DIV(DIV), .AUTO(1)) dutAuto (
        .clki(clki), .rs(rs), .btn_next(btnNext), .pause(pause),
        .led(ledO[0]), .mode(modeO[0]), .step_tick(stO[0]), .cycle_done(cdO[0])
    );

    led_seq_ctrl #(.DIV(DIV), .AUTO(0)) dutManual (
        .clki(clki), .rs(rs), .btn_next(btnNext), .pause(pause),
        .led(ledO[1]), .mode(modeO[1]), .step_tick(stO[1]), .cycle_done(cdO[1])
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mPcnt[k] = 0; mMode[k] = 0; mStep[k] = 0; mSt[k] = 0; mCd[k] = 0;
        end
    endtask

    task automatic modelEdge();
        bit tk;
        for (int k = 0; k < 2; k++) begin
            tk = (mPcnt[k] == DIV - 1) && !pause;
            if (btnNext) begin
                mMode[k] = (mMode[k] + 1) % 4;
                mStep[k] = 0; mPcnt[k] = 0; mSt[k] = 0; mCd[k] = 0;
            end else begin
                if (!pause) mPcnt[k] = (mPcnt[k] + 1) % DIV;
                mSt[k] = tk;
                mCd[k] = 0;
                if (tk) begin
                    mStep[k] = mStep[k] + 1;
                    if (mStep[k] == seqLen[mMode[k]]) begin
                        mStep[k] = 0;
                        mCd[k] = 1;
                        if (autoOf[k] != 0) mMode[k] = (mMode[k] + 1) % 4;
                    end
                end
            end
        end
    endtask

    task automatic stepClk();
        @(posedge clki);
        if (rs) modelEdge();
        #1;
    endtask

    task automatic doReset();
        btnNext = 1'b0;
        pause   = 1'b0;
        rs      = 1'b0;
        modelReset();
        repeat (2) stepClk();
        rs = 1'b1;
    endtask

    task automatic pulseBtn();
        btnNext = 1'b1;
        stepClk();
        btnNext = 1'b0;
    endtask

    task automatic test_reset();
        rs = 1'b1; btnNext = 1'b0; pause = 1'b0;
        #3;
        rs = 1'b0;
        modelReset();
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== 8'h00 || modeO[k] !== 2'd0 || stO[k] !== 1'b0 || cdO[k] !== 1'b0) begin
                    $display("[TB] FAIL reset inst=%0d led=%h mode=%0d st=%b cd=%b required 00/0/0/0",
                             k, ledO[k], modeO[k], stO[k], cdO[k]);
                end else passCount++;
            end
            stepClk();
        end
    endtask

    task automatic test_fill_up();
        doReset();
        for (int c = 1; c <= 40; c++) begin
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== seqTab[mMode[k]][mStep[k]] || modeO[k] !== 2'(mMode[k]) ||
                    stO[k] !== mSt[k] || cdO[k] !== mCd[k]) begin
                    $display("[TB] FAIL fill_up c=%0d inst=%0d led=%h/%h mode=%0d/%0d st=%b/%b cd=%b/%b",
                             c, k, ledO[k], seqTab[mMode[k]][mStep[k]], modeO[k], mMode[k],
                             stO[k], mSt[k], cdO[k], mCd[k]);
                end else passCount++;
            end
            if (c == 3 || c == 4 || c == 36) begin
                checkCount++;
                if ((c == 3 && ledO[0] !== 8'h00) || (c == 4 && ledO[0] !== 8'h01) ||
                    (c == 36 && (ledO[0] !== 8'h00 || modeO[0] !== 2'd1 || cdO[0] !== 1'b1))) begin
                    $display("[TB] FAIL fill_up_edge c=%0d led=%h mode=%0d cd=%b", c, ledO[0], modeO[0], cdO[0]);
                end else passCount++;
            end
        end
    endtask

    task automatic test_btn_next();
        doReset();
        repeat (5) stepClk();
        pulseBtn();
        checkCount++;
        if (modeO[0] !== 2'd1 || ledO[0] !== 8'h00 || modeO[1] !== 2'd1) begin
            $display("[TB] FAIL btn_next mode=%0d led=%h required 1/00", modeO[0], ledO[0]);
        end else passCount++;
        for (int c = 1; c <= 5; c++) begin
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== seqTab[mMode[k]][mStep[k]] || modeO[k] !== 2'(mMode[k]) ||
                    stO[k] !== mSt[k] || cdO[k] !== mCd[k]) begin
                    $display("[TB] FAIL btn_next_run c=%0d inst=%0d led=%h/%h st=%b/%b",
                             c, k, ledO[k], seqTab[mMode[k]][mStep[k]], stO[k], mSt[k]);
                end else passCount++;
            end
            if (c == 3 || c == 4) begin
                checkCount++;
                if ((c == 3 && ledO[0] !== 8'h00) || (c == 4 && ledO[0] !== 8'h80)) begin
                    $display("[TB] FAIL btn_next_step c=%0d led=%h", c, ledO[0]);
                end else passCount++;
            end
        end
    endtask

    task automatic test_pause();
        doReset();
        pulseBtn();
        pulseBtn();
        repeat (12) stepClk();
        checkCount++;
        if (ledO[0] !== 8'h08 || modeO[0] !== 2'd2) begin
            $display("[TB] FAIL pause_setup led=%h mode=%0d required 08/2", ledO[0], modeO[0]);
        end else passCount++;
        pause = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== 8'h08 || stO[k] !== 1'b0 || cdO[k] !== 1'b0 ||
                    ledO[k] !== seqTab[mMode[k]][mStep[k]]) begin
                    $display("[TB] FAIL pause_hold c=%0d inst=%0d led=%h st=%b required 08/0", c, k, ledO[k], stO[k]);
                end else passCount++;
            end
        end
        pause = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== seqTab[mMode[k]][mStep[k]] || stO[k] !== mSt[k]) begin
                    $display("[TB] FAIL pause_resume c=%0d inst=%0d led=%h/%h st=%b/%b",
                             c, k, ledO[k], seqTab[mMode[k]][mStep[k]], stO[k], mSt[k]);
                end else passCount++;
            end
        end
        checkCount++;
        if (ledO[0] !== 8'h10 || stO[0] !== 1'b1) begin
            $display("[TB] FAIL pause_release led=%h st=%b required 10/1", ledO[0], stO[0]);
        end else passCount++;
    endtask

    task automatic test_back_to_back();
        doReset();
        repeat (3) pulseBtn();
        repeat (3) stepClk();
        pulseBtn();
        for (int k = 0; k < 2; k++) begin
            checkCount++;
            if (modeO[k] !== 2'd0 || ledO[k] !== 8'h00 || stO[k] !== 1'b0 || cdO[k] !== 1'b0 ||
                modeO[k] !== 2'(mMode[k])) begin
                $display("[TB] FAIL btn_tick_collide inst=%0d mode=%0d led=%h st=%b cd=%b required 0/00/0/0",
                         k, modeO[k], ledO[k], stO[k], cdO[k]);
            end else passCount++;
        end
        stepClk();
        checkCount++;
        if (stO[0] !== 1'b0 || cdO[0] !== 1'b0 || modeO[0] !== 2'd0) begin
            $display("[TB] FAIL btn_tick_after st=%b cd=%b mode=%0d required 0/0/0", stO[0], cdO[0], modeO[0]);
        end else passCount++;
    endtask

    task automatic test_manual_wrap();
        doReset();
        pulseBtn();
        for (int c = 1; c <= 37; c++) begin
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== seqTab[mMode[k]][mStep[k]] || modeO[k] !== 2'(mMode[k]) ||
                    stO[k] !== mSt[k] || cdO[k] !== mCd[k]) begin
                    $display("[TB] FAIL manual_wrap c=%0d inst=%0d led=%h/%h mode=%0d/%0d cd=%b/%b",
                             c, k, ledO[k], seqTab[mMode[k]][mStep[k]], modeO[k], mMode[k], cdO[k], mCd[k]);
                end else passCount++;
            end
            if (c == 32 || c == 36 || c == 37) begin
                checkCount++;
                if ((c == 32 && ledO[1] !== 8'hFF) ||
                    (c == 36 && (ledO[1] !== 8'h00 || modeO[1] !== 2'd1 || cdO[1] !== 1'b1 || modeO[0] !== 2'd2)) ||
                    (c == 37 && cdO[1] !== 1'b0)) begin
                    $display("[TB] FAIL manual_wrap_edge c=%0d led=%h mode=%0d cd=%b", c, ledO[1], modeO[1], cdO[1]);
                end else passCount++;
            end
        end
    endtask

    task automatic test_async_reset();
        doReset();
        pulseBtn();
        pulseBtn();
        repeat (9) stepClk();
        #2;
        rs = 1'b0;
        modelReset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checkCount++;
            if (ledO[k] !== 8'h00 || modeO[k] !== 2'd0 || stO[k] !== 1'b0 || cdO[k] !== 1'b0) begin
                $display("[TB] FAIL async_reset inst=%0d led=%h mode=%0d required 00/0", k, ledO[k], modeO[k]);
            end else passCount++;
        end
        stepClk();
        rs = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            stepClk();
            checkCount++;
            if (ledO[0] !== seqTab[mMode[0]][mStep[0]] || stO[0] !== mSt[0] ||
                (c < 4 && ledO[0] !== 8'h00) || (c == 4 && (ledO[0] !== 8'h01 || stO[0] !== 1'b1))) begin
                $display("[TB] FAIL async_restart c=%0d led=%h st=%b", c, ledO[0], stO[0]);
            end else passCount++;
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 1500; c++) begin
            btnNext = ($urandom_range(0, 24) == 0);
            pause   = ($urandom_range(0, 5) == 0);
            stepClk();
            for (int k = 0; k < 2; k++) begin
                checkCount++;
                if (ledO[k] !== seqTab[mMode[k]][mStep[k]] || modeO[k] !== 2'(mMode[k]) ||
                    stO[k] !== mSt[k] || cdO[k] !== mCd[k]) begin
                    $display("[TB] FAIL random c=%0d inst=%0d led=%h/%h mode=%0d/%0d st=%b/%b cd=%b/%b",
                             c, k, ledO[k], seqTab[mMode[k]][mStep[k]], modeO[k], mMode[k],
                             stO[k], mSt[k], cdO[k], mCd[k]);
                end else passCount++;
            end
        end
        btnNext = 1'b0;
        pause   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_up();
        test_btn_next();
        test_pause();
        test_back_to_back();
        test_manual_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 25000000, meaning clki cycles per pattern step (legal range 2..2^26).
REQ-002 SHALL have parameter AUTO, default 1, meaning that 1 advances the mode automatically at the end of each pattern cycle.
REQ-003 SHALL have port clki, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rs, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_next, input, 1 bit: a single-cycle pulse, already synchronized, that requests the next mode.
REQ-006 SHALL have port pause, input, 1 bit: a level; 1 freezes the prescaler and the pattern.
REQ-007 SHALL have port led, output, 8 bits: the registered pattern.
REQ-008 SHALL have port mode, output, 2 bits: the current mode (0 FILL_UP, 1 FILL_DN, 2 CHASE, 3 BLINK).
REQ-009 SHALL have port step_tick, output, 1 bit: a one-cycle pulse on each pattern step.
REQ-010 SHALL have port cycle_done, output, 1 bit: a one-cycle pulse when the last step of a mode's pattern is left.

Function
REQ-011 Prescaler counter pcnt SHALL count 0..DIV-1 and wrap to 0; tick=1 when pcnt==DIV-1 and pause==0.
REQ-012 With pause=1, pcnt, step, mode and led SHALL hold; step_tick and cycle_done SHALL be 0.
REQ-013 On tick, step SHALL advance by 1, wrapping to 0 after the last index of the current mode's pattern.
REQ-014 FILL_UP sequence SHALL be 00,01,03,07,0F,1F,3F,7F,FF (hex; 9 steps, indices 0..8).
REQ-015 FILL_DN sequence SHALL be 00,80,C0,E0,F0,F8,FC,FE,FF (9 steps).
REQ-016 CHASE sequence SHALL be 01,02,04,08,10,20,40,80 (8 steps).
REQ-017 BLINK sequence SHALL be 00,FF repeated 4 times (8 steps).
REQ-018 led SHALL equal pattern(mode,step) on the same edge that mode/step update; there is no extra latency.
REQ-019 step_tick SHALL be registered and assert the cycle after the edge where tick=1.
REQ-020 cycle_done SHALL be registered and assert the cycle after the tick that wraps step to 0.
REQ-021 FSM states SHALL be FILL_UP->FILL_DN->CHASE->BLINK->FILL_UP, i.e. mode increments modulo 4.
REQ-022 A btn_next pulse SHALL advance the mode on that edge and clear step and pcnt to 0.
REQ-023 With AUTO=1, the mode SHALL advance on the wrapping tick; step becomes 0 of the new mode; cycle_done still pulses.
REQ-024 With AUTO=0, a wrapping tick SHALL restart the same mode at step 0.
REQ-025 If btn_next and tick coincide, btn_next SHALL win: exactly one mode advance; step and pcnt cleared; no step_tick or cycle_done.
REQ-026 btn_next SHALL be honoured while pause=1, advancing the mode and clearing step; the pattern stays frozen at step 0.
REQ-027 The first tick after reset release SHALL occur on the DIV-th rising edge.

Reset
REQ-028 When rs=0, the following SHALL apply immediately, independent of clki: mode=0, step=0, pcnt=0, led=8'h00, step_tick=0, cycle_done=0.
REQ-029 Reset asserted mid-pattern SHALL abort the pattern with no residual pulse after release.

Structure
REQ-030 Shared package led_seq_pkg SHALL hold the mode encodings, the per-mode pattern lengths (9,9,8,8) and the LED width constant 8.
REQ-031 The prescaler SHALL be a sub-module tick_gen (parameter DIV; inputs clki, rs, en, clr; output tick).
REQ-032 Pattern decode SHALL be a pure function of mode/step; RTL SHALL be 120-400 lines total.

Verification (DIV=4)
REQ-033 Scenario: rs low 2 cycles, release, AUTO=1 -> led=00 until edge 4; then 01,03,...,FF every 4 cycles; cycle_done one cycle after the 9th tick; mode=1; led=00.
REQ-034 Scenario: btn_next at cycle 6 in FILL_UP -> mode=1, led=00, pcnt=0; next led=80 four cycles later.
REQ-035 Scenario: pause=1 for 10 cycles while CHASE is at 08 -> led stays 08 and no step_tick; after release, 10 appears 4 cycles later (pcnt resumes from its held value).
REQ-036 Scenario: btn_next on the same edge as a tick in BLINK -> mode=0, led=00, no cycle_done, a single mode increment.
REQ-037 Scenario: AUTO=0 and FILL_DN run to FF then one more tick -> led=00, mode stays 1, cycle_done=1 for one cycle.
REQ-038 Scenario: rs pulsed low asynchronously mid-CHASE between edges -> led=00 and mode=0 immediately; sequence restarts per REQ-027.
